// File: rtl/mtable_lut_pkg.sv
// Shared widths, reset table contents and config-mode encoding for the mtable LUT.
// The optional write lock is enabled with MTABLE_LUT_LOCK_EN.
package mtable_pkg;

  localparam int MTABLE_IDX_W = 3;
  localparam int MTABLE_LUT_W = 8;
  localparam logic [MTABLE_LUT_W-1:0] MTABLE_INIT_XOR_AC = 8'h5A;

  typedef enum logic {
    CFG_LOAD_ALL  = 1'b0,
    CFG_WRITE_ONE = 1'b1
  } cfg_mode_e;

  function automatic logic lut_lookup(input logic [MTABLE_LUT_W-1:0] tbl,
                                      input logic [MTABLE_IDX_W-1:0] sel);
    return tbl[sel];
  endfunction

endpackage

// File: rtl/mtable_lut_if.sv
// Config bus between the LUT top level and its register block.
// cfg_lock exists only when MTABLE_LUT_LOCK_EN is defined.
interface mtable_lut_if;
  import mtable_pkg::*;

  logic                    cfg_we;
  cfg_mode_e               cfg_mode;
  logic [MTABLE_IDX_W-1:0] cfg_idx;
  logic [MTABLE_LUT_W-1:0] cfg_data;
  logic                    cfg_err;
`ifdef MTABLE_LUT_LOCK_EN
  logic                    cfg_lock;

  modport master (output cfg_we, cfg_mode, cfg_idx, cfg_data, cfg_lock, input cfg_err);
  modport slave  (input cfg_we, cfg_mode, cfg_idx, cfg_data, cfg_lock, output cfg_err);
`else
  modport master (output cfg_we, cfg_mode, cfg_idx, cfg_data, input cfg_err);
  modport slave  (input cfg_we, cfg_mode, cfg_idx, cfg_data, output cfg_err);
`endif

endinterface

// File: rtl/mtable_lut_cfg_regs.sv
// Table register plus optional sticky write lock and rejected-write pulse.
// Lock logic is built only with MTABLE_LUT_LOCK_EN.
module mtable_cfg_regs
  import mtable_pkg::*;
#(
  parameter logic [MTABLE_LUT_W-1:0] INIT = MTABLE_INIT_XOR_AC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mtable_lut_if.slave             cfg,
  output logic [MTABLE_LUT_W-1:0] o_table
);

  logic [MTABLE_LUT_W-1:0] r_table = INIT;
  logic                    w_locked;

`ifdef MTABLE_LUT_LOCK_EN
  logic r_lock;
  logic r_err;

  // A lock request in the same cycle as a write already blocks that write.
  assign w_locked = r_lock | cfg.cfg_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_lock <= r_lock | cfg.cfg_lock;
      r_err  <= cfg.cfg_we & w_locked;
    end
  end

  assign cfg.cfg_err = r_err;
`else
  assign w_locked    = 1'b0;
  assign cfg.cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table <= INIT;
    end else if (cfg.cfg_we && !w_locked) begin
      if (cfg.cfg_mode == CFG_WRITE_ONE) begin
        r_table[cfg.cfg_idx] <= cfg.cfg_data[0];
      end else begin
        r_table <= cfg.cfg_data;
      end
    end
  end

  assign o_table = r_table;

endmodule

// File: rtl/mtable_lut.sv
// Programmable 3-input truth table: z = table[{a,b,c}], combinational lookup.
// Define MTABLE_LUT_LOCK_EN to add the cfg_lock write-protect input.
module mtable_lut
  import mtable_pkg::*;
#(
  parameter logic [MTABLE_LUT_W-1:0] INIT = MTABLE_INIT_XOR_AC
) (
  output logic                    z,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic                    cfg_mode,
  input  logic [MTABLE_IDX_W-1:0] cfg_idx,
  input  logic [MTABLE_LUT_W-1:0] cfg_data,
`ifdef MTABLE_LUT_LOCK_EN
  input  logic                    cfg_lock,
`endif
  output logic                    cfg_err
);

  logic [MTABLE_LUT_W-1:0] w_table;

  mtable_lut_if w_cfg_if ();

  // Undriven or unknown strobes must never write the table.
  assign w_cfg_if.cfg_we   = (cfg_we === 1'b1);
  assign w_cfg_if.cfg_mode = cfg_mode_e'(cfg_mode);
  assign w_cfg_if.cfg_idx  = cfg_idx;
  assign w_cfg_if.cfg_data = cfg_data;
`ifdef MTABLE_LUT_LOCK_EN
  assign w_cfg_if.cfg_lock = (cfg_lock === 1'b1);
`endif
  assign cfg_err = w_cfg_if.cfg_err;

  mtable_cfg_regs #(
    .INIT (INIT)
  ) u_cfg_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg     (w_cfg_if.slave),
    .o_table (w_table)
  );

  assign z = lut_lookup(w_table, {a, b, c});

endmodule

// File: tb/tb_mtable_lut.sv
// Directed self-checking bench for mtable_lut: lookup sweep, writes, resets, lock.
module tb_mtable_lut;
  import mtable_pkg::*;

  logic clk;
  logic clk_run;
  logic rst_n;
  logic a, b, c;
  logic z;
  int   tests_run;
  int   tests_failed;

  mtable_lut_if cfg_bus ();

  mtable_lut dut (
    .z        (z),
    .a        (a),
    .b        (b),
    .c        (c),
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_bus.cfg_we),
    .cfg_mode (cfg_bus.cfg_mode),
    .cfg_idx  (cfg_bus.cfg_idx),
    .cfg_data (cfg_bus.cfg_data),
`ifdef MTABLE_LUT_LOCK_EN
    .cfg_lock (cfg_bus.cfg_lock),
`endif
    .cfg_err  (cfg_bus.cfg_err)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  // Sweep abc 0..7, one time unit per step, and compare z against the expected table.
  task automatic check_table(input string tag, input logic [7:0] exp_tbl);
    logic [7:0] t;
    t = exp_tbl;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      check($sformatf("%s[abc=%0d]", tag, i), z, t[i]);
    end
    $display("[TB] %s table sweep vs %h done", tag, exp_tbl);
  endtask

  task automatic do_write(input logic mode, input logic [2:0] idx, input logic [7:0] data);
    @(negedge clk);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_mode = cfg_mode_e'(mode);
    cfg_bus.cfg_idx  = idx;
    cfg_bus.cfg_data = data;
    @(negedge clk);
    cfg_bus.cfg_we   = 1'b0;
    $display("[TB] write mode=%0d idx=%0d data=%h", mode, idx, data);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_table("reset_async", 8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    clk_run          = 1'b0;
    rst_n            = 1'b1;
    {a, b, c}        = 3'b000;
    cfg_bus.cfg_we   = 1'b0;
    cfg_bus.cfg_mode = CFG_LOAD_ALL;
    cfg_bus.cfg_idx  = 3'd0;
    cfg_bus.cfg_data = 8'h00;
`ifdef MTABLE_LUT_LOCK_EN
    cfg_bus.cfg_lock = 1'b0;
`endif

    // No clock, no writes: power-up contents implement a ^ c.
    #1;
    check_table("init", 8'h5A);

    rst_n = 1'b0;
    #3;
    check("reset_err", cfg_bus.cfg_err, 1'b0);
    rst_n   = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);

    do_write(1'b0, 3'd0, 8'hFF);
    check("load_all_err", cfg_bus.cfg_err, 1'b0);
    check_table("load_ff", 8'hFF);

    // Reset with the clock held still must restore the table immediately.
    clk_run = 1'b0;
    #7;
    rst_n = 1'b0;
    #1;
    check_table("reset_noclk", 8'h5A);
    rst_n   = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);

    do_write(1'b1, 3'd5, 8'h01);
    check_table("write_one_5", 8'h7A);

    do_write(1'b1, 3'd1, 8'hFE);
    check_table("write_one_1_zero", 8'h78);

    do_write(1'b0, 3'd0, 8'h00);
    check_table("load_00", 8'h00);
    pulse_reset();

    // Back-to-back writes: the second one wins.
    @(negedge clk);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_mode = CFG_LOAD_ALL;
    cfg_bus.cfg_data = 8'h0F;
    @(negedge clk);
    cfg_bus.cfg_data = 8'hF0;
    @(negedge clk);
    cfg_bus.cfg_we   = 1'b0;
    {a, b, c} = 3'b111;
    #1;
    check("b2b_abc111", z, 1'b1);
    {a, b, c} = 3'b000;
    #1;
    check("b2b_abc000", z, 1'b0);
    check_table("b2b", 8'hF0);

    // Reset asserted while a write strobe is active: reset wins.
    @(negedge clk);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_data = 8'h33;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_write_err", cfg_bus.cfg_err, 1'b0);
    check_table("reset_mid_write", 8'h5A);
    @(negedge clk);
    cfg_bus.cfg_we = 1'b0;
    rst_n = 1'b1;

`ifdef MTABLE_LUT_LOCK_EN
    @(negedge clk);
    cfg_bus.cfg_lock = 1'b1;
    @(negedge clk);
    cfg_bus.cfg_lock = 1'b0;
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_mode = CFG_LOAD_ALL;
    cfg_bus.cfg_data = 8'h00;
    @(posedge clk);
    #1;
    check("lock_err_pulse", cfg_bus.cfg_err, 1'b1);
    @(negedge clk);
    cfg_bus.cfg_we = 1'b0;
    @(posedge clk);
    #1;
    check("lock_err_single", cfg_bus.cfg_err, 1'b0);
    check_table("locked", 8'h5A);
    pulse_reset();
    do_write(1'b0, 3'd0, 8'hC3);
    check_table("unlocked_after_reset", 8'hC3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
